// File: rtl/video_write_dma_if.sv
// AXI4 write-channel bundle used by video_write_dma (AW, W and B channels).
interface video_write_dma_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned AXI_ID_WIDTH   = 8
);
  logic [AXI_ID_WIDTH-1:0]     axi_awid;
  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
  logic [7:0]                  axi_awlen;
  logic [2:0]                  axi_awsize;
  logic [1:0]                  axi_awburst;
  logic [1:0]                  axi_awlock;
  logic                        axi_awvalid;
  logic                        axi_awready;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;
  logic                        axi_wvalid;
  logic                        axi_wready;
  logic [AXI_ID_WIDTH-1:0]     axi_bid;
  logic [1:0]                  axi_bresp;
  logic                        axi_bvalid;
  logic                        axi_bready;

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awvalid,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid
  );

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awvalid,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/video_write_dma.sv
// Video capture DMA: packs a raster pixel stream into bus words, buffers them in a word FIFO
// and writes them to memory with fixed-length AXI4 INCR bursts, one burst in flight at a time.
module video_write_dma #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned AXI_ID         = 0,
  parameter int unsigned BYTES_PER_PIX  = 4,
  parameter int unsigned PIXS_PER_CYC   = 2,
  parameter int unsigned IMG_WIDTH      = 1920,
  parameter int unsigned IN_WIDTH       = BYTES_PER_PIX * PIXS_PER_CYC * 8,
  parameter int unsigned STRIDE         = BYTES_PER_PIX * IMG_WIDTH,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned FIFO_DEPTH     = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic                      video_vsync,
  input  logic                      video_hsync,
  input  logic                      video_de,
  input  logic [IN_WIDTH-1:0]       video_data,
  video_write_dma_if.master         axi,
  output logic                      overflow,
  output logic                      resp_err,
  output logic                      busy
);

  localparam int unsigned Ratio      = AXI_DATA_WIDTH / IN_WIDTH;
  localparam int unsigned PackW      = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned BeatW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BurstBytesInt = BURST_LEN * AXI_DATA_WIDTH / 8;
  localparam int unsigned LineBytesInt  = BYTES_PER_PIX * IMG_WIDTH;

  localparam logic [AXI_ADDR_WIDTH-1:0] BurstBytes = AXI_ADDR_WIDTH'(BurstBytesInt);
  localparam logic [AXI_ADDR_WIDTH-1:0] LineBytes  = AXI_ADDR_WIDTH'(LineBytesInt);
  localparam logic [AXI_ADDR_WIDTH-1:0] StrideA    = AXI_ADDR_WIDTH'(STRIDE);
  localparam logic [PackW-1:0]          PackLast   = PackW'(Ratio - 1);
  localparam logic [BeatW-1:0]          BeatLast   = BeatW'(BURST_LEN - 1);
  localparam logic [PtrW:0]             BurstCount = (PtrW + 1)'(BURST_LEN);
  localparam logic [PtrW:0]             FullCount  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                    state_q;
  logic                      awvalid_q, wvalid_q, wlast_q, busy_q, resp_err_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, burst_addr_q, line_addr_q, col_bytes_q;
  logic [AXI_ADDR_WIDTH-1:0] col_next;
  logic [BeatW-1:0]          beat_q;

  logic [AXI_DATA_WIDTH-1:0] pack_q;
  logic [PackW-1:0]          pack_cnt_q;
  logic                      push_q;
  logic                      beat_valid;

  logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]           wptr_q, rptr_q;
  logic [PtrW:0]             count_q;
  logic                      overflow_q;
  logic                      full, push_ok, pop, flush;

  assign beat_valid = video_de && video_hsync && video_vsync;

  // Shift input beats into the pack register; a completed word is pushed on the next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_q     <= '0;
      pack_cnt_q <= '0;
      push_q     <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (!video_hsync) begin
        // Line end: any partial word is discarded.
        pack_cnt_q <= '0;
      end else if (beat_valid) begin
        pack_q[pack_cnt_q * IN_WIDTH +: IN_WIDTH] <= video_data;
        if (pack_cnt_q == PackLast) begin
          pack_cnt_q <= '0;
          push_q     <= 1'b1;
        end else begin
          pack_cnt_q <= pack_cnt_q + 1'b1;
        end
      end
    end
  end

  // Word FIFO control. The video side never stalls, so a push into a full FIFO is dropped.
  assign full    = (count_q == FullCount);
  assign push_ok = push_q && !full;
  assign pop     = (state_q == StData) && wvalid_q && axi.axi_wready;
  assign flush   = (state_q == StIdle) && !video_vsync;

  // FIFO storage; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wptr_q] <= pack_q;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag (cleared by a frame restart).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_q && full) overflow_q <= 1'b1;
      count_q <= count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop);
    end
  end

  assign col_next = col_bytes_q + BurstBytes;

  // Burst sequencer: restart handling, AW issue with address stepping, W beats, B response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_err_q   <= 1'b0;
      awaddr_q     <= '0;
      burst_addr_q <= '0;
      line_addr_q  <= '0;
      col_bytes_q  <= '0;
      beat_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!video_vsync) begin
            line_addr_q  <= base_addr;
            burst_addr_q <= base_addr;
            col_bytes_q  <= '0;
            resp_err_q   <= 1'b0;
          end else if (count_q >= BurstCount) begin
            awvalid_q <= 1'b1;
            awaddr_q  <= burst_addr_q;
            busy_q    <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (axi.axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (BURST_LEN == 1);
            beat_q    <= '0;
            state_q   <= StData;
            if (col_next == LineBytes) begin
              line_addr_q  <= line_addr_q + StrideA;
              burst_addr_q <= line_addr_q + StrideA;
              col_bytes_q  <= '0;
            end else begin
              burst_addr_q <= burst_addr_q + BurstBytes;
              col_bytes_q  <= col_next;
            end
          end
        end
        StData: begin
          if (axi.axi_wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              state_q  <= StResp;
            end else begin
              beat_q  <= beat_q + 1'b1;
              wlast_q <= ((beat_q + 1'b1) == BeatLast);
            end
          end
        end
        StResp: begin
          if (axi.axi_bvalid) begin
            if (axi.axi_bresp != 2'b00) resp_err_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_bid;
  assign unused_bid = ^axi.axi_bid;

  assign axi.axi_awid    = AXI_ID_WIDTH'(AXI_ID);
  assign axi.axi_awaddr  = awaddr_q;
  assign axi.axi_awlen   = 8'(BURST_LEN - 1);
  assign axi.axi_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign axi.axi_awburst = 2'b01;
  assign axi.axi_awlock  = 2'b00;
  assign axi.axi_awvalid = awvalid_q;
  assign axi.axi_wdata   = mem_q[rptr_q];
  assign axi.axi_wstrb   = '1;
  assign axi.axi_wlast   = wlast_q;
  assign axi.axi_wvalid  = wvalid_q;
  assign axi.axi_bready  = 1'b1;

  assign overflow = overflow_q;
  assign resp_err = resp_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_video_write_dma.sv
// Randomized bench for video_write_dma: a queue-based model predicts every written word and
// every burst address from the raster geometry; a monitor checks the AXI write traffic.
module tb_video_write_dma;
  localparam int unsigned AW = 32, DW = 128, IDW = 8, AxiId = 5;
  localparam int unsigned Bpp = 4, Ppc = 2, ImgW = 16, InW = Bpp * Ppc * 8;
  localparam int unsigned Stride = 256, BurstLen = 4, FifoDepth = 8;
  localparam int unsigned BurstBytes    = BurstLen * DW / 8;
  localparam int unsigned LineBytes     = Bpp * ImgW;
  localparam int unsigned BurstsPerLine = LineBytes / BurstBytes;
  localparam int unsigned BeatsPerLine  = ImgW / Ppc;
  localparam int unsigned BeatsPerWord  = DW / InW;
  localparam int unsigned WordsPerLine  = LineBytes * 8 / DW;

  logic           clk = 1'b0;
  logic           rstn;
  logic [AW-1:0]  base_addr;
  logic           vsync, hsync, de;
  logic [InW-1:0] vdata;
  logic           overflow, resp_err, busy;

  video_write_dma_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)) axi_if ();

  video_write_dma #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW), .AXI_ID(AxiId),
    .BYTES_PER_PIX(Bpp), .PIXS_PER_CYC(Ppc), .IMG_WIDTH(ImgW), .IN_WIDTH(InW),
    .STRIDE(Stride), .BURST_LEN(BurstLen), .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk(clk), .rstn(rstn), .base_addr(base_addr),
    .video_vsync(vsync), .video_hsync(hsync), .video_de(de), .video_data(vdata),
    .axi(axi_if), .overflow(overflow), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_words[$];
  logic [AW-1:0] exp_addr[$];
  int aw_mode = 0, w_mode = 0, b_pending = 0, beat_idx = 0, n_bursts = 0, n_beats = 0;
  bit err_next = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling edge, between input changes and active edges.
  initial begin
    logic          prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_wait = 1'b0;
        beat_idx  = 0;
      end else begin
        if (axi_if.axi_awvalid && prev_wait) check_eq("aw_stable", axi_if.axi_awaddr, prev_addr);
        if (axi_if.axi_awvalid && axi_if.axi_awready) begin
          n_bursts++;
          check_eq("aw_expected", exp_addr.size() != 0, 1);
          if (exp_addr.size() != 0) check_eq("awaddr", axi_if.axi_awaddr, exp_addr.pop_front());
          check_eq("awlen", axi_if.axi_awlen, BurstLen - 1);
          check_eq("awsize", axi_if.axi_awsize, 4);
          check_eq("awburst", axi_if.axi_awburst, 1);
          check_eq("awid", axi_if.axi_awid, AxiId);
        end
        prev_wait = axi_if.axi_awvalid && !axi_if.axi_awready;
        prev_addr = axi_if.axi_awaddr;
        if (axi_if.axi_wvalid && axi_if.axi_wready) begin
          n_beats++;
          check_eq("w_expected", exp_words.size() != 0, 1);
          if (exp_words.size() != 0) check_eq("wdata", axi_if.axi_wdata, exp_words.pop_front());
          check_eq("wlast", axi_if.axi_wlast, beat_idx == BurstLen - 1);
          check_eq("wstrb", axi_if.axi_wstrb, {(DW / 8){1'b1}});
          if (beat_idx == BurstLen - 1) begin
            beat_idx = 0;
            b_pending++;
          end else begin
            beat_idx++;
          end
        end
      end
    end
  end

  // AW/W ready generation according to the current mode.
  initial begin
    int aw_wait = 0;
    axi_if.axi_awready = 1'b0;
    axi_if.axi_wready  = 1'b0;
    forever begin
      tick();
      if (aw_mode == 0) begin
        axi_if.axi_awready = 1'b1;
      end else if (aw_mode == 1) begin
        if (axi_if.axi_awvalid && !axi_if.axi_awready) begin
          if (aw_wait >= 5) axi_if.axi_awready = 1'b1;
          else aw_wait++;
        end else begin
          axi_if.axi_awready = 1'b0;
          aw_wait = 0;
        end
      end else begin
        axi_if.axi_awready = 1'b0;
      end
      if (w_mode == 0) axi_if.axi_wready = 1'b1;
      else axi_if.axi_wready = ~axi_if.axi_wready;
    end
  end

  // Write-response generation: one single-cycle B beat per completed burst.
  initial begin
    axi_if.axi_bvalid = 1'b0;
    axi_if.axi_bresp  = 2'b00;
    axi_if.axi_bid    = '0;
    forever begin
      tick();
      if (axi_if.axi_bvalid) begin
        axi_if.axi_bvalid = 1'b0;
      end else if (b_pending > 0 && rstn) begin
        b_pending--;
        repeat ($urandom_range(0, 2)) tick();
        axi_if.axi_bvalid = 1'b1;
        axi_if.axi_bresp  = err_next ? 2'b10 : 2'b00;
        axi_if.axi_bid    = IDW'($urandom);
        err_next = 1'b0;
      end
    end
  end

  task automatic restart(input logic [AW-1:0] base);
    base_addr = base;
    vsync = 1'b0;
    hsync = 1'b0;
    de    = 1'b0;
    repeat (4) tick();
  endtask

  // Send a frame; only the first keep_words packed words are expected to reach memory.
  task automatic send_frame(input logic [AW-1:0] base, input int nlines, input int keep_words,
                            input int hblank);
    int            words = 0;
    logic [DW-1:0] w = '0;
    for (int k = 0; k < keep_words / BurstLen; k++) begin
      exp_addr.push_back(base + AW'((k / BurstsPerLine) * Stride)
                              + AW'((k % BurstsPerLine) * BurstBytes));
    end
    vsync = 1'b1;
    repeat (3) tick();
    for (int l = 0; l < nlines; l++) begin
      hsync = 1'b1;
      tick();
      for (int b = 0; b < BeatsPerLine; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          de = 1'b0;
          repeat ($urandom_range(1, 2)) tick();
        end
        de    = 1'b1;
        vdata = {$urandom, $urandom};
        w[(b % BeatsPerWord) * InW +: InW] = vdata;
        if (b % BeatsPerWord == BeatsPerWord - 1) begin
          if (words < keep_words) exp_words.push_back(w);
          words++;
        end
        tick();
      end
      de = 1'b0;
      tick();
      hsync = 1'b0;
      repeat (hblank) tick();
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while ((exp_words.size() != 0 || exp_addr.size() != 0 || busy || b_pending != 0 ||
            axi_if.axi_bvalid) && t < 3000) begin
      tick();
      t++;
    end
    check_eq(tag, t < 3000, 1);
    repeat (2) tick();
  endtask

  initial begin
    int            b0, w0, t;
    logic [AW-1:0] base;
    rstn = 1'b0; base_addr = '0; vsync = 1'b0; hsync = 1'b0; de = 1'b0; vdata = '0;
    repeat (3) tick();
    check_eq("rst_awvalid", axi_if.axi_awvalid, 0);
    check_eq("rst_wvalid", axi_if.axi_wvalid, 0);
    check_eq("rst_wlast", axi_if.axi_wlast, 0);
    check_eq("rst_awaddr", axi_if.axi_awaddr, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("bready", axi_if.axi_bready, 1);
    rstn = 1'b1;
    tick();

    // Basic 2-line frame, ready always high: bursts at 0x1000 and 0x1100.
    b0 = n_bursts; w0 = n_beats;
    restart(32'h1000);
    send_frame(32'h1000, 2, 2 * WordsPerLine, 8);
    wait_drain("drain_basic");
    check_eq("basic_bursts", n_bursts - b0, 2);
    check_eq("basic_beats", n_beats - w0, 8);
    check_eq("basic_overflow", overflow, 0);
    check_eq("basic_resp_err", resp_err, 0);

    // Slow AW (5-cycle delay) and toggling wready, random base including wrap-around.
    aw_mode = 1; w_mode = 1;
    b0 = n_bursts;
    base = $urandom & 32'hFFFF_FFC0;
    restart(base);
    send_frame(base, 3, 3 * WordsPerLine, 16);
    wait_drain("drain_slow");
    check_eq("slow_bursts", n_bursts - b0, 3);
    check_eq("slow_overflow", overflow, 0);

    // AW held off for 3 lines: FIFO keeps the first 8 words, the rest are dropped.
    aw_mode = 2; w_mode = 0;
    base = 32'h0002_0000;
    restart(base);
    send_frame(base, 3, FifoDepth, 4);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_busy", busy, 1);
    check_eq("ovf_awvalid", axi_if.axi_awvalid, 1);
    aw_mode = 0;
    wait_drain("drain_ovf");
    check_eq("ovf_sticky", overflow, 1);
    base = 32'h0003_0040;
    restart(base);
    check_eq("ovf_cleared", overflow, 0);
    send_frame(base, 2, 2 * WordsPerLine, 6);
    wait_drain("drain_after_ovf");
    check_eq("after_ovf_overflow", overflow, 0);

    // Error response on the first burst; the second burst still goes out.
    b0 = n_bursts;
    err_next = 1'b1;
    restart(32'h0000_4000);
    send_frame(32'h0000_4000, 2, 2 * WordsPerLine, 6);
    wait_drain("drain_err");
    check_eq("err_resp_err", resp_err, 1);
    check_eq("err_bursts", n_bursts - b0, 2);
    restart(32'h0000_5000);
    check_eq("err_cleared", resp_err, 0);

    // Reset in the middle of a data burst.
    w_mode = 1;
    send_frame(32'h0000_5000, 1, WordsPerLine, 0);
    t = 0;
    while (!axi_if.axi_wvalid && t < 200) begin
      tick();
      t++;
    end
    check_eq("mid_data_reached", t < 200, 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_mid_awvalid", axi_if.axi_awvalid, 0);
    check_eq("rst_mid_wvalid", axi_if.axi_wvalid, 0);
    check_eq("rst_mid_busy", busy, 0);
    exp_words.delete();
    exp_addr.delete();
    b_pending = 0;
    axi_if.axi_bvalid = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_awaddr", axi_if.axi_awaddr, 0);
    b0 = n_bursts;
    base = 32'h0000_8000;
    restart(base);
    send_frame(base, 2, 2 * WordsPerLine, 8);
    wait_drain("drain_post_rst");
    check_eq("post_rst_bursts", n_bursts - b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_write_dma.md
Name: video_write_dma

Overview:
- Capture-side counterpart of the frame-buffer read path: accepts a raster video stream (vsync/hsync/de/data) and writes it into DRAM through an AXI4 write master.
- Packs PIXS_PER_CYC pixels per cycle into AXI_DATA_WIDTH words and buffers them in an internal word FIFO.
- Issues fixed-length INCR bursts, one outstanding burst at a time.
- Single clock domain; the video source must already be synchronous to clk.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 128, AXI data width; must be a multiple of IN_WIDTH.
- AXI_ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant driven on axi_awid.
- BYTES_PER_PIX, 4, bytes per pixel.
- PIXS_PER_CYC, 2, pixels per input beat.
- IMG_WIDTH, 1920, pixels per active line; line bytes must be a multiple of BURST_LEN*AXI_DATA_WIDTH/8.
- IN_WIDTH, BYTES_PER_PIX*PIXS_PER_CYC*8, video_data width.
- STRIDE, BYTES_PER_PIX*IMG_WIDTH, byte distance between line start addresses.
- BURST_LEN, 16, beats per burst (1..256).
- FIFO_DEPTH, 64, word FIFO depth; power of two, >= 2*BURST_LEN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- base_addr  in  AXI_ADDR_WIDTH  frame base byte address; sampled at frame restart
- video_vsync  in  1  low = vertical blanking
- video_hsync  in  1  low = horizontal blanking
- video_de  in  1  pixel beat valid
- video_data  in  IN_WIDTH  pixel data; first pixel in the LSBs
- axi_awid  out  AXI_ID_WIDTH  constant AXI_ID
- axi_awaddr  out  AXI_ADDR_WIDTH  burst address
- axi_awlen  out  8  constant BURST_LEN-1
- axi_awsize  out  3  constant log2(AXI_DATA_WIDTH/8)
- axi_awburst  out  2  constant 2'b01 (INCR)
- axi_awlock  out  2  constant 0
- axi_awvalid  out  1  address valid
- axi_awready  in  1  address ready
- axi_wdata  out  AXI_DATA_WIDTH  write data
- axi_wstrb  out  AXI_DATA_WIDTH/8  constant all ones
- axi_wlast  out  1  last beat of burst
- axi_wvalid  out  1  data valid
- axi_wready  in  1  data ready
- axi_bid  in  AXI_ID_WIDTH  ignored
- axi_bresp  in  2  write response
- axi_bvalid  in  1  response valid
- axi_bready  out  1  constant 1
- overflow  out  1  sticky: a packed word was dropped
- resp_err  out  1  sticky: bresp != OKAY was received
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release) values: awvalid=0, wvalid=0, wlast=0, awaddr=0, overflow=0, resp_err=0, busy=0; FIFO empty; pack counter=0.
- Packing: each cycle with de=1 && hsync=1 && vsync=1, shift video_data into the pack register at slot pack_cnt*IN_WIDTH. On slot AXI_DATA_WIDTH/IN_WIDTH-1, push the word into the FIFO next cycle and wrap pack_cnt to 0. Pack latency: 1 cycle from the final beat to FIFO count increment.
- Line end: pack_cnt is cleared on hsync=0, which discards any partial word. No partial word can occur with legal parameters.
- FIFO full: if a push occurs while full, drop the word and set overflow. Never stall the video side.
- Frame restart: while vsync=0, a restart is pending. The restart executes only in IDLE and does the following:
  - flush the FIFO;
  - set line_addr = burst_addr = base_addr;
  - clear col_bytes, overflow and resp_err.
- In-flight bursts are never aborted.
- FSM states:
  - IDLE: if a restart is pending, execute it and stay in IDLE. Otherwise, if fifo_count >= BURST_LEN, assert awvalid with awaddr=burst_addr and go to ADDR.
  - ADDR: hold awvalid and awaddr stable until awready. Then deassert awvalid, update the address (below), and go to DATA.
  - DATA: wvalid=1, wdata=FIFO head (first-word-fall-through, registered). Pop on wvalid&&wready. wlast=1 on beat BURST_LEN-1. After the last handshake, deassert wvalid and go to RESP.
  - RESP: wait for bvalid. If bresp != 2'b00, set resp_err. Return to IDLE.
- Address update on AW handshake: col_bytes += BURST_LEN*AXI_DATA_WIDTH/8.
  - If col_bytes reaches BYTES_PER_LINE, then line_addr += STRIDE, burst_addr = new line_addr, col_bytes = 0.
  - Otherwise burst_addr += burst bytes.
  - All arithmetic is modulo 2^AXI_ADDR_WIDTH.
- A FIFO pop and push in the same cycle keeps the count unchanged. A push while full is dropped even if a pop happens that cycle (a registered full flag is acceptable).
- The AW channel is never asserted before the FIFO holds a full burst, so wvalid never drops mid-burst.

Test Plan:
- Params IMG_WIDTH=16, BYTES_PER_PIX=4, PIXS_PER_CYC=2, AXI_DATA_WIDTH=128, BURST_LEN=4, STRIDE=64; one 2-line frame, base_addr=0x1000, ready always 1 -> two bursts at awaddr 0x1000 and 0x1040, awlen=3, 4 beats each, wlast on beat 3, word0 = {pix3,pix2,pix1,pix0}.
- Same, STRIDE=0x100 -> second burst at 0x1100.
- awready delayed 5 cycles, wready toggling every other cycle -> awaddr/awvalid stable until handshake; beats in order, no duplicates or loss.
- FIFO_DEPTH=8, awready held 0 for 3 lines -> overflow=1, FIFO holds the first 8 words. Next vsync low in IDLE clears overflow, and the next frame writes from base_addr.
- bresp=2'b10 on first burst -> resp_err=1, second burst still issued normally.
- rstn asserted mid-DATA -> awvalid/wvalid drop immediately. After release: IDLE, busy=0, FIFO empty, and the next frame writes from base_addr.
